cache_app_arb: RTL

CACHE_APP_ARB -- requirements
Module: cache_app_arb

---
 rtl/cache_app_arb.sv | 109 ++++++++++
 1 files changed

// File: rtl/cache_app_arb.sv
// cache_app_arb: two-master burst arbiter sharing one application bus between icache refill and dcache FSMs.
// Ports:
//   mclk, rst_n           clock (rising edge) and asynchronous active-low reset
//   m_stb_i/adr/we/dat/sel/bl   per-master burst requests (bit/slice 0 = icache, 1 = dcache)
//   m_dat_o, m_ack_o, m_lack_o  read data broadcast plus per-master beat / last-beat acks
//   s_stb_o/adr/we/dat/sel/bl   shared application bus request, driven by the granted master
//   s_dat_i, s_ack_i, s_lack_i  application bus response
//   gnt_o                 registered one-hot grant, 2'b00 while idle
// Define CACHE_ARB_RR_EN for round-robin arbitration; otherwise the icache has fixed priority.
module cache_app_arb #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
) (
    input  logic               mclk,
    input  logic               rst_n,
    input  logic [1:0]         m_stb_i,
    input  logic [2*WB_AW-1:0] m_adr_i,
    input  logic [1:0]         m_we_i,
    input  logic [2*WB_DW-1:0] m_dat_i,
    input  logic [7:0]         m_sel_i,
    input  logic [19:0]        m_bl_i,
    output logic [WB_DW-1:0]   m_dat_o,
    output logic [1:0]         m_ack_o,
    output logic [1:0]         m_lack_o,
    output logic               s_stb_o,
    output logic [WB_AW-1:0]   s_adr_o,
    output logic               s_we_o,
    output logic [WB_DW-1:0]   s_dat_o,
    output logic [3:0]         s_sel_o,
    output logic [9:0]         s_bl_o,
    input  logic [WB_DW-1:0]   s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_lack_i,
    output logic [1:0]         gnt_o
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [9:0] beat_cnt_q, beat_cnt_d;
`ifdef CACHE_ARB_RR_EN
    logic       last_q, last_d;
`endif
    logic       busy, g, live, win;

    assign busy = state_q == BUSY;
    assign g    = gnt_q[1];
    // granted master still holding its strobe; acks are only forwarded while this holds
    assign live = busy & m_stb_i[g];
`ifdef CACHE_ARB_RR_EN
    assign win  = (m_stb_i == 2'b11) ? ~last_q : m_stb_i[1];
`else
    assign win  = ~m_stb_i[0];
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
`ifdef CACHE_ARB_RR_EN
        last_d     = last_q;
`endif
        if (!busy) begin
            if (|m_stb_i) begin
                state_d    = BUSY;
                gnt_d      = win ? 2'b10 : 2'b01;
                beat_cnt_d = '0;
`ifdef CACHE_ARB_RR_EN
                last_d     = win;
`endif
            end
        end else if (!live || s_lack_i) begin
            state_d = IDLE;
            gnt_d   = '0;
        end
        if (live && s_ack_i && beat_cnt_q != 10'h3FF)
            beat_cnt_d = beat_cnt_q + 10'd1;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
`ifdef CACHE_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
`ifdef CACHE_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    always_comb begin
        s_stb_o  = live;
        s_adr_o  = busy ? (g ? m_adr_i[WB_AW +: WB_AW] : m_adr_i[0 +: WB_AW]) : '0;
        s_we_o   = busy & m_we_i[g];
        s_dat_o  = busy ? (g ? m_dat_i[WB_DW +: WB_DW] : m_dat_i[0 +: WB_DW]) : '0;
        s_sel_o  = busy ? (g ? m_sel_i[7:4] : m_sel_i[3:0]) : '0;
        s_bl_o   = busy ? (g ? m_bl_i[19:10] : m_bl_i[9:0]) : '0;
        m_dat_o  = busy ? s_dat_i : '0;
        m_ack_o  = {2{live & s_ack_i}} & gnt_q;
        m_lack_o = {2{live & s_lack_i}} & gnt_q;
        gnt_o    = gnt_q;
    end
endmodule
